matrix_frame_sched: RTL and testbench
=====================================

Name: matrix_frame_sched

Overview:
- Sequences the 8x8 serial LED matrix frame serializer.
- Issues one start pulse per frame and waits for the serializer's done.
- Enforces an inter-frame latch gap, advances the 0..7 scroll shift, and rotates the displayed digit pair at each shift wrap.
- Sits between the io_in digit-select lines and the serializer that drives clock/data to the strip; adds a watchdog for a hung serializer.

Parameters:
- DIGIT_W, 1, width of the digit/font index.
- GAP_CYCLES, 64, idle cycles between serializer done and next start (strip latch time); legal range 1..65535.
- TIMEOUT, 4096, max cycles in WAIT before the watchdog fires; must be >= 2.
- FRAMES_PER_STEP, 1, frames shown per scroll position; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; level sensitive
- digit_in  in  DIGIT_W  next digit to enter the display
- ser_done  in  1  one-cycle pulse from serializer: frame fully shifted out
- ser_start  out  1  one-cycle pulse: serializer begins a frame
- ser_shift  out  3  left-shift amount for the current frame
- ser_digit_a  out  DIGIT_W  leaving (left) digit
- ser_digit_b  out  DIGIT_W  entering (right) digit
- frame_count  out  8  completed frames, wraps 255->0
- busy  out  1  high in START, WAIT and GAP
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (reset low, asynchronous):
  - state=INIT; ser_start=0, ser_shift=0, ser_digit_a=0, ser_digit_b=0, frame_count=0, busy=0, timeout_err=0.
  - All internal counters 0.
- All outputs are registered.
- INIT: lasts exactly one cycle after reset release. Loads ser_digit_a and ser_digit_b from digit_in, then goes to IDLE.
- IDLE: if enable=1, go to START. Otherwise stay.
- START: ser_start=1 for this one cycle, watchdog cleared, then go to WAIT.
  - Latency: enable sampled high in IDLE at cycle t gives ser_start high at cycle t+1.
- WAIT:
  - ser_done=1: frame_count+1, go to GAP.
  - Otherwise, if the watchdog reaches TIMEOUT-1: timeout_err=1, go to GAP. The frame counts as not completed; frame_count is unchanged.
  - ser_done and watchdog expiry in the same cycle: done wins, no error.
- GAP:
  - Stays exactly GAP_CYCLES cycles. ser_done sampled at cycle t puts START at cycle t+GAP_CYCLES+1 when enable=1.
  - On the last GAP cycle the scroll step runs.
  - Next state is START if enable=1, else IDLE.
- Scroll step:
  - A repeat counter counts frames at the current position.
  - When it reaches FRAMES_PER_STEP-1 it resets to 0 and the shift advances:
    - If ser_shift=7: ser_shift=0, ser_digit_a<=ser_digit_b, ser_digit_b<=digit_in (sampled that cycle).
    - Otherwise: ser_shift+1.
  - A timed-out frame also advances the step; the display keeps scrolling.
- ser_shift and the digit outputs change only at GAP exit, so they are stable from ser_start through ser_done.
- ser_done outside WAIT is ignored.
- enable dropping mid-frame: the current WAIT and GAP complete, then IDLE. No truncated frame.
- err_clr=1 clears timeout_err. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame: immediate return to reset values; any serializer handshake in flight is abandoned.
- Widths: watchdog counter is clog2(TIMEOUT) bits, gap counter 16 bits, repeat counter clog2(FRAMES_PER_STEP+1) bits. No arithmetic overflow is permitted inside the legal parameter ranges.

Optional Feature:
- Macro: MATRIX_FRAME_SCHED_SPEED_EN.
- With the macro defined:
  - Adds input speed[3:0].
  - Frames per scroll position = speed+1 (1..16), sampled each time the repeat counter resets to 0.
  - A change of speed mid-step takes effect at the next step.
  - FRAMES_PER_STEP is ignored.
- Without the macro: no speed port; FRAMES_PER_STEP is fixed.

Test Plan:
- Reset then enable=1 with digit_in=1, GAP_CYCLES=4, serializer answering done 10 cycles after start:
  - ser_digit_a=ser_digit_b=1 after INIT.
  - ser_start period is 1+10+4 cycles.
  - ser_shift steps 0,1,...,7,0.
- Digit rotation:
  - Change digit_in 1->0 during shift 3.
  - At the 7->0 wrap: ser_digit_a=1, ser_digit_b=0.
  - frame_count=8 after the 8th done.
- Watchdog with TIMEOUT=16 and no ser_done:
  - timeout_err=1 exactly 16 cycles after ser_start; frame_count stays 0; ser_shift still advances.
  - err_clr pulse clears the flag.
  - err_clr asserted on the expiry cycle leaves the flag at 1.
- Drop enable during WAIT:
  - Done arrives, GAP completes, state goes to IDLE with busy=0 and no further ser_start.
  - Re-enable gives ser_start 1 cycle later.
- Assert reset mid-GAP at shift=5: all outputs return to 0 asynchronously, before the next clock edge.
- Spurious ser_done in IDLE/GAP: no frame_count change. FRAMES_PER_STEP=3: shift advances once per 3 frames. With MATRIX_FRAME_SCHED_SPEED_EN and speed=1: advances once per 2 frames.

Source files
------------

// File: rtl/matrix_frame_sched.sv
// Frame scheduler for the 8x8 serial LED matrix: start/done handshake, latch gap,
// scroll shift and digit rotation, watchdog. Optional MATRIX_FRAME_SCHED_SPEED_EN adds a speed input.
module matrix_frame_sched #(
    parameter int DIGIT_W         = 1,
    parameter int GAP_CYCLES      = 64,
    parameter int TIMEOUT         = 4096,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               ser_done,
    input  logic               err_clr,
`ifdef MATRIX_FRAME_SCHED_SPEED_EN
    input  logic [3:0]         speed,
`endif
    output logic               ser_start,
    output logic [2:0]         ser_shift,
    output logic [DIGIT_W-1:0] ser_digit_a,
    output logic [DIGIT_W-1:0] ser_digit_b,
    output logic [7:0]         frame_count,
    output logic               busy,
    output logic               timeout_err,
    output logic [2:0]         dbg_state
);

    // Handshake: ser_start is a one-cycle pulse opening a frame; the serializer answers
    // with a one-cycle ser_done pulse, which is only honoured while waiting for it.
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT);
`ifdef MATRIX_FRAME_SCHED_SPEED_EN
    localparam int REP_W = 4;
`else
    localparam int REP_W = $clog2(FRAMES_PER_STEP + 1);
`endif

    state_t           state;
    state_t           state_nx;
    logic [WD_W-1:0]  wd_cnt;
    logic [15:0]      gap_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_last;
    logic             wd_expire;
    logic             gap_last;
    logic             done_ev;
    logic             tmo_ev;
    logic             step_ev;

`ifdef MATRIX_FRAME_SCHED_SPEED_EN
    // Step length is latched when a new scroll position begins.
    logic [3:0] spd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spd_q <= 4'd0;
        end else if (state == S_INIT || (step_ev && rep_cnt == rep_last)) begin
            spd_q <= speed;
        end
    end

    assign rep_last = spd_q;
`else
    assign rep_last = REP_W'(FRAMES_PER_STEP - 1);
`endif

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign gap_last  = (gap_cnt == 16'(GAP_CYCLES - 1));
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        done_ev  = 1'b0;
        tmo_ev   = 1'b0;
        step_ev  = 1'b0;
        case (state)
            S_INIT:  state_nx = S_IDLE;
            S_IDLE:  if (enable) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (ser_done) begin
                    done_ev  = 1'b1;
                    state_nx = S_GAP;
                end else if (wd_expire) begin
                    tmo_ev   = 1'b1;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    step_ev  = 1'b1;
                    state_nx = enable ? S_START : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            ser_start   <= 1'b0;
            busy        <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            rep_cnt     <= '0;
            ser_shift   <= 3'd0;
            ser_digit_a <= '0;
            ser_digit_b <= '0;
            frame_count <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nx;
            ser_start <= (state_nx == S_START);
            busy      <= (state_nx == S_START) || (state_nx == S_WAIT) || (state_nx == S_GAP);

            // Counts START plus WAIT cycles; never exceeds TIMEOUT-1.
            if (state_nx == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
            else                    wd_cnt <= '0;

            if (state == S_GAP && !gap_last) gap_cnt <= gap_cnt + 16'd1;
            else                             gap_cnt <= 16'd0;

            if (done_ev) frame_count <= frame_count + 8'd1;

            if (tmo_ev)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            if (state == S_INIT) begin
                ser_digit_a <= digit_in;
                ser_digit_b <= digit_in;
            end

            if (step_ev) begin
                if (rep_cnt == rep_last) begin
                    rep_cnt <= '0;
                    if (ser_shift == 3'd7) begin
                        ser_shift   <= 3'd0;
                        ser_digit_a <= ser_digit_b;
                        ser_digit_b <= digit_in;
                    end else begin
                        ser_shift <= ser_shift + 3'd1;
                    end
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_sched.sv
// Bench for matrix_frame_sched: two instances (1 and 3 frames per step) sharing stimulus,
// frame scoreboard popped at each ser_start, plus directed watchdog/enable/reset checks.
module tb_matrix_frame_sched;
    localparam int DIGIT_W = 1;
    localparam int GAP     = 4;
    localparam int TMO     = 16;
    localparam int LAT     = 10;
    localparam int FW      = 3 + 2 * DIGIT_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               ser_done;
    logic               err_clr;
    logic [DIGIT_W-1:0] digit_in;

    logic               ser_start, busy, timeout_err;
    logic [2:0]         ser_shift, dbg_state;
    logic [DIGIT_W-1:0] ser_digit_a, ser_digit_b;
    logic [7:0]         frame_count;

    logic               ser_start3, busy3, timeout_err3;
    logic [2:0]         ser_shift3, dbg_state3;
    logic [DIGIT_W-1:0] ser_digit_a3, ser_digit_b3;
    logic [7:0]         frame_count3;

`ifdef MATRIX_FRAME_SCHED_SPEED_EN
    logic [3:0] speed1 = 4'd0;
    logic [3:0] speed3 = 4'd2;
`endif

    matrix_frame_sched #(.DIGIT_W(DIGIT_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .FRAMES_PER_STEP(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_in(digit_in),
        .ser_done(ser_done), .err_clr(err_clr),
`ifdef MATRIX_FRAME_SCHED_SPEED_EN
        .speed(speed1),
`endif
        .ser_start(ser_start), .ser_shift(ser_shift), .ser_digit_a(ser_digit_a),
        .ser_digit_b(ser_digit_b), .frame_count(frame_count), .busy(busy),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    matrix_frame_sched #(.DIGIT_W(DIGIT_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .FRAMES_PER_STEP(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .digit_in(digit_in),
        .ser_done(ser_done), .err_clr(err_clr),
`ifdef MATRIX_FRAME_SCHED_SPEED_EN
        .speed(speed3),
`endif
        .ser_start(ser_start3), .ser_shift(ser_shift3), .ser_digit_a(ser_digit_a3),
        .ser_digit_b(ser_digit_b3), .frame_count(frame_count3), .busy(busy3),
        .timeout_err(timeout_err3), .dbg_state(dbg_state3)
    );

    always #5 clk = ~clk;

    logic [FW-1:0] exp_q[$];
    logic [2:0]    exp3_q[$];
    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int n_starts   = 0;
    int last_start = 0;
    int ser_cnt    = 0;
    bit per_chk    = 1'b0;
    bit ser_auto   = 1'b1;
    bit spur       = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int shift, input int a, input int b, input int shift3);
        exp_q.push_back({3'(shift), DIGIT_W'(a), DIGIT_W'(b)});
        exp3_q.push_back(3'(shift3));
    endtask

    // One cycle: sample outputs at the falling edge, then drive the serializer model.
    task automatic tick();
        logic [FW-1:0] e;
        logic [2:0]    e3;
        @(negedge clk);
        cyc++;
        ser_done = 1'b0;
        if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) ser_done = 1'b1;
        end
        if (spur) begin
            ser_done = 1'b1;
            spur     = 1'b0;
        end
        if (ser_start) begin
            n_starts++;
            check("sb_empty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame", {ser_shift, ser_digit_a, ser_digit_b}, e);
            end
            if (per_chk) check("period", cyc - last_start, 1 + LAT + GAP);
            last_start = cyc;
            if (ser_auto) ser_cnt = LAT;
        end
        if (ser_start3) begin
            check("sb3_empty", exp3_q.size() != 0, 1);
            if (exp3_q.size() != 0) begin
                e3 = exp3_q.pop_front();
                check("frame3", ser_shift3, e3);
            end
        end
    endtask

    initial begin
        int g;
        reset    = 1'b0;
        enable   = 1'b0;
        ser_done = 1'b0;
        err_clr  = 1'b0;
        digit_in = DIGIT_W'(1);
        repeat (3) tick();
        check("rst_start", ser_start, 0);
        check("rst_shift", ser_shift, 0);
        check("rst_a", ser_digit_a, 0);
        check("rst_b", ser_digit_b, 0);
        check("rst_fc", frame_count, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);

        reset = 1'b1;
        tick();
        check("init_a", ser_digit_a, 1);
        check("init_b", ser_digit_b, 1);
        check("idle_busy", busy, 0);

        // Continuous run: 17 frames, digit_in drops to 0 during shift 3.
        for (int k = 0; k < 17; k++)
            push_frame(k % 8, (k < 16) ? 1 : 0, (k < 8) ? 1 : 0, (k / 3) % 8);
        enable = 1'b1;
        tick();
        check("start_lat", ser_start, 1);
        per_chk = 1'b1;
        g = 0;
        while (n_starts < 17 && g < 400) begin
            tick();
            g++;
            if (ser_start) check("fcount", frame_count, n_starts - 1);
            if (n_starts == 4) digit_in = DIGIT_W'(0);
        end
        check("run_done", n_starts, 17);
        per_chk = 1'b0;

        // Drop enable during WAIT of frame 16.
        tick();
        enable = 1'b0;
        g = 0;
        while (busy && g < 60) begin
            tick();
            g++;
        end
        check("drop_idle", busy, 0);
        repeat (20) tick();
        check("no_start", n_starts, 17);
        check("drop_fc", frame_count, 17);
        check("drop_shift", ser_shift, 1);
        check("drop_shift3", ser_shift3, 5);
        check("drop_a", ser_digit_a, 0);

        // Re-enable with a silent serializer: watchdog fires.
        ser_auto = 1'b0;
        push_frame(1, 0, 0, 5);
        enable = 1'b1;
        tick();
        check("reen_lat", ser_start, 1);
        repeat (15) tick();
        check("tmo_pre", timeout_err, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_set_wins", timeout_err, 1);
        check("tmo_fc", frame_count, 17);
        check("tmo_busy", busy, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", timeout_err, 0);
        ser_auto = 1'b1;
        push_frame(2, 0, 0, 6);
        tick();
        tick();
        check("after_tmo_start", ser_start, 1);

        // Spurious done in GAP and in IDLE.
        repeat (11) tick();
        spur = 1'b1;
        tick();
        enable = 1'b0;
        g = 0;
        while (busy && g < 20) begin
            tick();
            g++;
        end
        check("spur_idle", busy, 0);
        spur = 1'b1;
        repeat (3) tick();
        check("spur_fc", frame_count, 18);
        check("spur_shift", ser_shift, 3);
        check("spur_shift3", ser_shift3, 6);

        // Reset asserted in the GAP of the shift-5 frame.
        push_frame(3, 0, 0, 6);
        push_frame(4, 0, 0, 6);
        push_frame(5, 0, 0, 7);
        enable = 1'b1;
        g = 0;
        while (n_starts < 22 && g < 100) begin
            tick();
            g++;
        end
        check("reach_shift5", n_starts, 22);
        repeat (12) tick();
        check("pre_rst_shift", ser_shift, 5);
        check("pre_rst_shift3", ser_shift3, 7);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_fc", frame_count, 21);
        reset   = 1'b0;
        enable  = 1'b0;
        ser_cnt = 0;
        #1;
        check("arst_shift", ser_shift, 0);
        check("arst_shift3", ser_shift3, 0);
        check("arst_busy", busy, 0);
        check("arst_fc", frame_count, 0);
        check("arst_start", ser_start, 0);
        repeat (2) tick();
        check("q_empty", exp_q.size(), 0);
        check("q3_empty", exp3_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
